// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Brief  : Shared constants and FSM state encoding for the divider control unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD     = 4'd1,
    S_CHECK    = 4'd2,
    S_SHL_INIT = 4'd3,
    S_TEST     = 4'd4,
    S_SUB      = 4'd5,
    S_SHL0     = 4'd6,
    S_SHL1     = 4'd7,
    S_FIX      = 4'd8,
    S_DONE     = 4'd9,
    S_ERR      = 4'd10
  } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_cu.sv
// ============================================================================
// Module : div_cu
// Brief  : Moore control unit for a restoring shift/subtract divider.
//          Define DIV_CU_ZERO_CHECK_EN to add the CHECK/ERR divide-by-zero path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_cu
  import div_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       R_lt_Y,
  input  logic [3:0] cnt_out,
  input  logic       error,
  output logic       udCE,
  output logic       udLD,
  output logic       udUD,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       rLD,
  output logic       rSL,
  output logic       rSR,
  output logic       xLD,
  output logic       xSL,
  output logic       xRightIn,
  output logic       yLD,
  output logic       done,
  output logic       div_err
);

  div_state_e r_state;
  div_state_e w_next;

`ifndef DIV_CU_ZERO_CHECK_EN
  logic w_unused_error;
  assign w_unused_error = error;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     w_next = go ? S_LOAD : S_IDLE;
`ifdef DIV_CU_ZERO_CHECK_EN
      S_LOAD:     w_next = S_CHECK;
      S_CHECK:    w_next = error ? S_ERR : S_SHL_INIT;
      S_ERR:      w_next = go ? S_ERR : S_IDLE;
`else
      S_LOAD:     w_next = S_SHL_INIT;
`endif
      S_SHL_INIT: w_next = S_TEST;
      // An exhausted counter ends the loop even if the remainder is small.
      S_TEST: begin
        if (cnt_out == 4'(0)) begin
          w_next = S_FIX;
        end else if (R_lt_Y) begin
          w_next = S_SHL0;
        end else begin
          w_next = S_SUB;
        end
      end
      S_SUB:      w_next = S_SHL1;
      S_SHL0:     w_next = S_TEST;
      S_SHL1:     w_next = S_TEST;
      S_FIX:      w_next = S_DONE;
      S_DONE:     w_next = go ? S_DONE : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    udCE     = 1'b0;
    udLD     = 1'b0;
    udUD     = 1'b0;
    s0       = 1'b0;
    s1       = 1'b0;
    s2       = 1'b0;
    rLD      = 1'b0;
    rSL      = 1'b0;
    rSR      = 1'b0;
    xLD      = 1'b0;
    xSL      = 1'b0;
    xRightIn = 1'b0;
    yLD      = 1'b0;
    done     = 1'b0;
    div_err  = 1'b0;
    case (r_state)
      S_LOAD: begin
        xLD  = 1'b1;
        yLD  = 1'b1;
        rLD  = 1'b1;
        s0   = 1'b1;
        udLD = 1'b1;
      end
      S_SHL_INIT: begin
        rSL = 1'b1;
        xSL = 1'b1;
      end
      S_SUB: begin
        rLD = 1'b1;
      end
      S_SHL0: begin
        rSL  = 1'b1;
        xSL  = 1'b1;
        udCE = 1'b1;
      end
      S_SHL1: begin
        rSL      = 1'b1;
        xSL      = 1'b1;
        udCE     = 1'b1;
        xRightIn = 1'b1;
      end
      S_FIX: begin
        rSR = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        s1   = 1'b1;
        s2   = 1'b1;
      end
`ifdef DIV_CU_ZERO_CHECK_EN
      S_ERR: begin
        done    = 1'b1;
        div_err = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire
